// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and encodings for the multicycle MIPS-subset
//                core: opcodes, funct codes, FSM states, ALU control.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

  typedef logic [31:0] word_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // One state per instruction cycle
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_IEXEC   = 4'd8,
    ST_IWB     = 4'd9,
    ST_BRANCH  = 4'd10,
    ST_JUMP    = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8
  } alu_ctrl_e;

  function automatic word_t sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // True for the R-type functions that go through EXECUTE/ALUWB
  function automatic logic funct_valid(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
      FN_NOR, FN_SLT, FN_SLL, FN_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic alu_ctrl_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_XOR:  return ALU_XOR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic alu_ctrl_e iop_to_alu(input logic [5:0] opcode);
    case (opcode)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mips_alu
//  Description : Combinational 32-bit ALU. Shifts act on b by shamt; slt is
//                a signed compare. zero flags an all-zero result.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_alu
  import mips_pkg::*;
(
  input  word_t       a,
  input  word_t       b,
  input  logic [4:0]  shamt,
  input  alu_ctrl_e   alu_ctrl,
  output word_t       result,
  output logic        zero
);

  // Operation select
  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/mips_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle
//  Description : Multicycle 32-bit MIPS-subset core on one unified word-wide
//                memory port. Regfile, FSM and datapath registers live here;
//                arithmetic is delegated to mips_alu.
//                Optional macro MIPS_JAL_JR_EN adds jal and jr.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_multicycle
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    NREGS    = 32
) (
  input  logic        clk,
  input  logic        rstb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] PC
);

  state_e     state_q, state_d, decode_next;
  word_t      pc_q, pc_d;
  word_t      ir_q, ir_d;
  word_t      mdr_q, mdr_d;
  word_t      a_q, a_d;
  word_t      b_q, b_d;
  word_t      aluout_q, aluout_d;
  word_t      regs_q [NREGS];

  logic       rf_we;
  logic [4:0] rf_waddr;
  word_t      rf_wdata;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm;
  word_t      rs_val, rt_val, jump_target;

  word_t      alu_a, alu_b, alu_result;
  alu_ctrl_e  alu_ctrl;
  logic       alu_zero;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];

  // PC has already advanced past the jump, so the region bits come from PC+4
  assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

  // r0 and any index beyond the implemented file read as zero
  assign rs_val = (rs == 5'd0 || int'(rs) >= NREGS) ? '0 : regs_q[rs];
  assign rt_val = (rt == 5'd0 || int'(rt) >= NREGS) ? '0 : regs_q[rt];

  mips_alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .shamt    (shamt),
    .alu_ctrl (alu_ctrl),
    .result   (alu_result),
    .zero     (alu_zero)
  );

  // ALU operand and operation select by state
  always_comb begin
    alu_a    = a_q;
    alu_b    = b_q;
    alu_ctrl = ALU_ADD;
    case (state_q)
      ST_MEMADR:  alu_b = sign_ext(imm);
      ST_EXECUTE: alu_ctrl = funct_to_alu(funct);
      ST_IEXEC: begin
        alu_b    = (opcode == OP_ANDI || opcode == OP_ORI) ? {16'b0, imm} : sign_ext(imm);
        alu_ctrl = iop_to_alu(opcode);
      end
      ST_BRANCH:  alu_ctrl = ALU_SUB;
      default:    ;
    endcase
  end

  // Opcode dispatch out of DECODE; anything unrecognised returns to FETCH
  always_comb begin
    decode_next = ST_FETCH;
    case (opcode)
      OP_RTYPE: begin
        if (funct_valid(funct)) decode_next = ST_EXECUTE;
`ifdef MIPS_JAL_JR_EN
        else if (funct == FN_JR) decode_next = ST_JUMP;
`endif
      end
      OP_J:                               decode_next = ST_JUMP;
`ifdef MIPS_JAL_JR_EN
      OP_JAL:                             decode_next = ST_JUMP;
`endif
      OP_BEQ, OP_BNE:                     decode_next = ST_BRANCH;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  decode_next = ST_IEXEC;
      OP_LW, OP_SW:                       decode_next = ST_MEMADR;
      default:                            decode_next = ST_FETCH;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = aluout_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = mem_rd_data;
        pc_d    = pc_q + 32'd4;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        a_d      = rs_val;
        b_d      = rt_val;
        aluout_d = pc_q + (sign_ext(imm) << 2);
        state_d  = decode_next;
      end
      ST_MEMADR: begin
        aluout_d = alu_result;
        state_d  = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        mdr_d   = mem_rd_data;
        state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        state_d  = ST_FETCH;
      end
      ST_MEMWR:   state_d = ST_FETCH;
      ST_EXECUTE: begin
        aluout_d = alu_result;
        state_d  = ST_ALUWB;
      end
      ST_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_d  = ST_FETCH;
      end
      ST_IEXEC: begin
        aluout_d = alu_result;
        state_d  = ST_IWB;
      end
      ST_IWB: begin
        rf_we   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        if ((opcode == OP_BEQ && alu_zero) || (opcode == OP_BNE && !alu_zero))
          pc_d = aluout_q;
        state_d = ST_FETCH;
      end
      ST_JUMP: begin
`ifdef MIPS_JAL_JR_EN
        if (opcode == OP_RTYPE) begin
          pc_d = a_q;
        end else begin
          pc_d = jump_target;
          if (opcode == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_q;
          end
        end
`else
        pc_d = jump_target;
`endif
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  // Register file write port; writes to r0 are dropped
  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0) && (int'(rf_waddr) < NREGS)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Memory port; the write strobe is gated by reset so an in-flight store is dropped
  assign mem_addr    = (state_q == ST_MEMRD || state_q == ST_MEMWR) ? aluout_q : pc_q;
  assign mem_wr_data = b_q;
  assign mem_wr_ena  = (state_q == ST_MEMWR) && !rstb;
  assign PC          = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multicycle
//  Description : Bench for mips_multicycle: instruction-level reference model
//                with per-cycle port expectations, a directed program and
//                randomized programs, plus a reset-during-store scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data, dut_pc;
  logic        mem_wr_ena;

  always #5 clk = ~clk;

  mips_multicycle #(.RESET_PC(32'h0), .NREGS(32)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .PC          (dut_pc)
  );

  // 1 KiB unified memory; ld copies the prepared image in one clock
  logic [31:0] mem [256];
  logic [31:0] img [256];
  logic        ld = 1'b0;
  int          cnt40 = 0;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_wr_ena) begin
      mem[mem_addr[9:2]] <= mem_wr_data;
      if (mem_addr == 32'h40) cnt40 <= cnt40 + 1;
    end
  end
  assign mem_rd_data = mem[mem_addr[9:2]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- encoders / image builder ----------------
  int wp;
  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_j(int op, logic [31:0] addr);
    return {6'(op), addr[27:2]};
  endfunction
  task automatic put(input logic [31:0] w);
    img[wp] = w;
    wp++;
  endtask
  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'h0;
    wp = 0;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mregs [32];
  logic [31:0] mmem  [256];
  logic [31:0] mpc;

  // Executes instructions one at a time; for each, checks every cycle's PC,
  // address, strobe and store data against what the ISA timing rules require.
  task automatic run_model(input int max_instr, output int halt_cycle);
    logic [31:0] ins, a, b, sext, zext, pc4, npc, ea, wval, exp_pc, exp_addr;
    logic [5:0]  op, fn;
    int rs, rt, rd, sh, ncyc, wreg, cyc, halts;
    logic is_mem, is_sw, wr_reg;
    cyc = 0; halts = 0; halt_cycle = -1;
    mpc = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    for (int i = 0; i < 256; i++) mmem[i] = img[i];
    for (int k = 0; k < max_instr && halts < 34; k++) begin
      ins  = mmem[mpc[9:2]];
      op   = ins[31:26]; fn = ins[5:0];
      rs   = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]); sh = int'(ins[10:6]);
      sext = {{16{ins[15]}}, ins[15:0]};
      zext = {16'h0, ins[15:0]};
      a = mregs[rs]; b = mregs[rt];
      pc4 = mpc + 32'd4; npc = pc4;
      ncyc = 2; is_mem = 0; is_sw = 0; wr_reg = 0; wreg = 0; wval = 0; ea = 0;
      case (op)
        6'h00: begin
          ncyc = 4; wr_reg = 1; wreg = rd;
          case (fn)
            6'h20: wval = a + b;
            6'h22: wval = a - b;
            6'h24: wval = a & b;
            6'h25: wval = a | b;
            6'h26: wval = a ^ b;
            6'h27: wval = ~(a | b);
            6'h2A: wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: wval = b << sh;
            6'h02: wval = b >> sh;
`ifdef MIPS_JAL_JR_EN
            6'h08: begin ncyc = 3; wr_reg = 0; npc = a; end
`endif
            default: begin ncyc = 2; wr_reg = 0; end
          endcase
        end
        6'h02: begin ncyc = 3; npc = {pc4[31:28], ins[25:0], 2'b00}; end
`ifdef MIPS_JAL_JR_EN
        6'h03: begin ncyc = 3; npc = {pc4[31:28], ins[25:0], 2'b00}; wr_reg = 1; wreg = 31; wval = pc4; end
`endif
        6'h04: begin ncyc = 3; if (a == b) npc = pc4 + (sext << 2); end
        6'h05: begin ncyc = 3; if (a != b) npc = pc4 + (sext << 2); end
        6'h08: begin ncyc = 4; wr_reg = 1; wreg = rt; wval = a + sext; end
        6'h0A: begin ncyc = 4; wr_reg = 1; wreg = rt; wval = ($signed(a) < $signed(sext)) ? 32'd1 : 32'd0; end
        6'h0C: begin ncyc = 4; wr_reg = 1; wreg = rt; wval = a & zext; end
        6'h0D: begin ncyc = 4; wr_reg = 1; wreg = rt; wval = a | zext; end
        6'h23: begin ncyc = 5; is_mem = 1; ea = a + sext; wr_reg = 1; wreg = rt; wval = mmem[ea[9:2]]; end
        6'h2B: begin ncyc = 4; is_mem = 1; is_sw = 1; ea = a + sext; end
        default: ncyc = 2;
      endcase
      if (op == 6'h02 && npc == mpc) begin
        if (halts == 0) halt_cycle = cyc;
        halts++;
      end
      for (int c = 0; c < ncyc; c++) begin
        #1;
        exp_pc   = (c == 0) ? mpc : pc4;
        exp_addr = (is_mem && c == 3) ? ea : exp_pc;
        chk("pc", dut_pc, exp_pc);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wr_ena", {31'b0, mem_wr_ena}, {31'b0, (is_sw && c == 3)});
        if (is_sw && c == 3) chk("mem_wr_data", mem_wr_data, b);
        @(negedge clk);
        cyc++;
      end
      if (wr_reg && wreg != 0) mregs[wreg] = wval;
      if (is_sw) mmem[ea[9:2]] = b;
      mpc = npc;
    end
    chk("halt_reached", 32'(halts), 32'd34);
  endtask

  // Load image and hold reset for five rising edges, then release
  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b1;
    ld   = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_pc", dut_pc, 32'h0);
    chk("rst_wr_ena", {31'b0, mem_wr_ena}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rstb = 1'b0;
  endtask

  task automatic build_directed();
    clear_img();
    put(enc_j(2, 32'h80));
    wp = 32'h80 >> 2;
    put(enc_i(8, 0, 1, 16'd5));          // 80 addi r1,r0,5
    put(enc_i(8, 0, 2, 16'hFFFD));       // 84 addi r2,r0,-3
    put(enc_r(1, 2, 3, 0, 'h20));        // 88 add r3,r1,r2
    put(enc_r(2, 1, 4, 0, 'h22));        // 8C sub r4,r2,r1
    put(enc_r(2, 1, 5, 0, 'h2A));        // 90 slt r5,r2,r1
    put(enc_i('h2B, 0, 1, 16'h40));      // 94 sw r1,0x40
    put(enc_i('h23, 0, 6, 16'h40));      // 98 lw r6,0x40
    put(enc_i(4, 1, 1, 16'd2));          // 9C beq r1,r1,+2
    put(enc_i(8, 0, 7, 16'd1));          // A0 skipped
    put(enc_i(8, 0, 7, 16'd2));          // A4 skipped
    put(enc_i(5, 1, 1, 16'd1));          // A8 bne r1,r1 (not taken)
    put(enc_i(8, 0, 0, 16'd7));          // AC addi r0,r0,7
    put(enc_i('h2B, 0, 0, 16'h44));      // B0 sw r0
    put(enc_i('h2B, 0, 3, 16'h48));
    put(enc_i('h2B, 0, 4, 16'h4C));
    put(enc_i('h2B, 0, 5, 16'h50));
    put(enc_i('h2B, 0, 6, 16'h54));
    put(enc_i('h2B, 0, 7, 16'h58));      // C4
    put(enc_j(2, 32'hC8));               // C8 halt
  endtask

  task automatic gen_random();
    int kind, f;
    logic [5:0] fn;
    clear_img();
    for (int r = 1; r < 8; r++) put(enc_i(8, 0, r, 16'($urandom)));
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: begin
          f = $urandom_range(0, 10);
          case (f)
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
            4: fn = 6'h26; 5: fn = 6'h27; 6: fn = 6'h2A; 7: fn = 6'h00;
            8: fn = 6'h02; 9: fn = 6'h21;
`ifdef MIPS_JAL_JR_EN
            default: fn = 6'h3F;
`else
            default: fn = 6'h08;
`endif
          endcase
          put(enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 31), int'(fn)));
        end
        3, 4: begin
          f = $urandom_range(0, 3);
          put(enc_i((f == 0) ? 8 : (f == 1) ? 'h0A : (f == 2) ? 'h0C : 'h0D,
                    $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)));
        end
        5: put(enc_i('h2B, 0, $urandom_range(0, 7), 16'(32'h200 + 4 * $urandom_range(0, 63))));
        6: put(enc_i('h23, 0, $urandom_range(0, 7), 16'(32'h200 + 4 * $urandom_range(0, 63))));
        7: put(enc_i($urandom_range(4, 5), $urandom_range(0, 7), $urandom_range(0, 7),
                     16'($urandom_range(0, 3))));
        8: begin
`ifdef MIPS_JAL_JR_EN
          f = $urandom_range(0, 1);
`else
          f = $urandom_range(0, 2);
`endif
          put({(f == 0) ? 6'h01 : (f == 1) ? 6'h3F : 6'h03, 26'($urandom)});
        end
        default: put(enc_i(8, 0, 0, 16'($urandom)));
      endcase
    end
    for (int r = 1; r < 8; r++) put(enc_i('h2B, 0, r, 16'(32'h300 + 4 * r)));
    while (wp < 128) put(enc_j(2, 32'(wp * 4)));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int hc, bad, n;
    rstb = 1'b1;

    // Directed program with hand-computed results
    build_directed();
    do_reset();
    run_model(200, hc);
    chk("halt_cycle", 32'(hc), 32'd66);
    chk("model_r3", mregs[3], 32'd2);
    chk("model_r4", mregs[4], 32'hFFFF_FFF8);
    chk("model_r6", mregs[6], 32'd5);
    chk("sw_0x40", mem[32'h40 >> 2], 32'd5);
    chk("sw_r0", mem[32'h44 >> 2], 32'd0);
    chk("add_r3", mem[32'h48 >> 2], 32'd2);
    chk("sub_r4", mem[32'h4C >> 2], 32'hFFFF_FFF8);
    chk("slt_r5", mem[32'h50 >> 2], 32'd1);
    chk("lw_r6", mem[32'h54 >> 2], 32'd5);
    chk("beq_skip_r7", mem[32'h58 >> 2], 32'd0);
    chk("sw40_pulses", 32'(cnt40), 32'd1);

    // Randomized programs
    for (int p = 0; p < 4; p++) begin
      gen_random();
      do_reset();
      run_model(400, hc);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== mmem[i]) bad++;
      chk("mem_image", 32'(bad), 32'd0);
    end

    // Reset asserted while the store is on the bus
    clear_img();
    put(enc_i(8, 0, 1, 16'd9));
    put(enc_i('h2B, 0, 1, 16'h80));
    put(enc_j(2, 32'h08));
    do_reset();
    n = 0;
    #1;
    while (!mem_wr_ena && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_memwr", {31'b0, mem_wr_ena}, 32'd1);
    rstb = 1'b1;
    #1;
    chk("rst_gates_wr", {31'b0, mem_wr_ena}, 32'd0);
    @(posedge clk);
    #1;
    chk("no_store", mem[32'h80 >> 2], 32'd0);
    chk("pc_after_rst", dut_pc, 32'd0);
    chk("addr_after_rst", mem_addr, 32'd0);
    @(negedge clk);
    rstb = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
